// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module : vga_pkg
// Brief  : Shared 640x480@60 timing constants, NES image geometry and the
//          9-bit RRRGGGBBB colour type used by the VGA output stage.
// Rev    : 1.0  initial release
//============================================================================
package vga_pkg;

    typedef logic [8:0] rgb9_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int NES_W       = 256;
    localparam int NES_H       = 240;
    localparam int SCALE_SHIFT = 1;

    // Colour bar k: each primary fully on when its bit of k is set.
    function automatic rgb9_t bar_rgb(input logic [2:0] k);
        return {{3{k[2]}}, {3{k[1]}}, {3{k[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pipe_delay.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module : vga_pipe_delay
// Brief  : WIDTH x DEPTH shift register with a synchronous reset value.
// Rev    : 1.0  initial release
//============================================================================
module vga_pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] w_chain [DEPTH+1];

    assign w_chain[0] = i_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] r_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= RESET_VAL;
            end else begin
                r_q <= w_chain[i];
            end
        end

        assign w_chain[i+1] = r_q;
    end

    assign o_q = w_chain[DEPTH];

endmodule
`default_nettype wire

// File: rtl/vga_timing.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module : vga_timing
// Brief  : 640x480@60 raster generator, 2x-scaled centred 256x240 frame
//          buffer addressing, colour re-alignment and DAC/sync pin drive.
// Config : VGA_TESTPAT_EN adds tp_sel, replacing the image with 8 colour bars.
// Rev    : 1.0  initial release
//============================================================================
module vga_timing
    import vga_pkg::*;
#(
    parameter int         H_ACTIVE   = VGA_H_ACTIVE,
    parameter int         H_FP       = VGA_H_FP,
    parameter int         H_SYNC     = VGA_H_SYNC,
    parameter int         H_BP       = VGA_H_BP,
    parameter int         V_ACTIVE   = VGA_V_ACTIVE,
    parameter int         V_FP       = VGA_V_FP,
    parameter int         V_SYNC     = VGA_V_SYNC,
    parameter int         V_BP       = VGA_V_BP,
    parameter int         X_OFFSET   = 64,
    parameter int         FB_LATENCY = 1,
    parameter logic [8:0] BORDER_RGB = 9'h000
) (
    input  wire logic       pix_clk,
    input  wire logic       reset,
    output logic      [7:0] pix_ptr_x,
    output logic      [7:0] pix_ptr_y,
    input  wire logic [8:0] rgb,
`ifdef VGA_TESTPAT_EN
    input  wire logic       tp_sel,
`endif
    output logic      [2:0] vga_r,
    output logic      [2:0] vga_g,
    output logic      [2:0] vga_b,
    output logic            vga_hs,
    output logic            vga_vs,
    output logic            vga_blank,
    output logic            vblank_start
);

    localparam logic [9:0] c_h_last   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_v_last   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_h_act    = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_act    = 10'(V_ACTIVE);
    localparam logic [9:0] c_hs_start = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] c_x_lo     = 10'(X_OFFSET);
    localparam logic [9:0] c_x_hi     = 10'(X_OFFSET + (NES_W << SCALE_SHIFT));
    localparam logic [7:0] c_last_row = 8'(NES_H - 1);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    always_ff @(posedge pix_clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_last) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    logic w_active;
    logic w_hs_n;
    logic w_vs_n;
    logic w_img;

    assign w_active = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    assign w_hs_n   = !((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end));
    assign w_vs_n   = !((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end));
    assign w_img    = w_active && (r_h_cnt >= c_x_lo) && (r_h_cnt < c_x_hi);

    logic [7:0] r_ptr_x;
    logic [7:0] r_ptr_y;

    // Blanked rows park on the last image row so the frame buffer never sees an out-of-range row.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            r_ptr_x <= '0;
            r_ptr_y <= '0;
        end else begin
            r_ptr_x <= w_img ? 8'((r_h_cnt - c_x_lo) >> SCALE_SHIFT) : 8'd0;
            r_ptr_y <= (r_v_cnt < c_v_act) ? 8'(r_v_cnt >> SCALE_SHIFT) : c_last_row;
        end
    end

    assign pix_ptr_x = r_ptr_x;
    assign pix_ptr_y = r_ptr_y;

    logic w_act_dly;
    logic w_hs_n_dly;
    logic w_vs_n_dly;
    logic w_img_dly;

`ifdef VGA_TESTPAT_EN
    localparam int c_dl_w = 7;
    logic [2:0] w_bar_raw;
    logic [2:0] w_bar_dly;
    assign w_bar_raw = 3'(((r_h_cnt - c_x_lo) >> SCALE_SHIFT) >> 5);
`else
    localparam int c_dl_w = 4;
`endif

    // Idle value: inactive, syncs deasserted, outside the image.
    localparam logic [c_dl_w-1:0] c_dl_rst = c_dl_w'(4'b0110);

    logic [c_dl_w-1:0] w_dl_in;
    logic [c_dl_w-1:0] w_dl_out;

`ifdef VGA_TESTPAT_EN
    assign w_dl_in = {w_bar_raw, w_active, w_hs_n, w_vs_n, w_img};
    assign {w_bar_dly, w_act_dly, w_hs_n_dly, w_vs_n_dly, w_img_dly} = w_dl_out;
`else
    assign w_dl_in = {w_active, w_hs_n, w_vs_n, w_img};
    assign {w_act_dly, w_hs_n_dly, w_vs_n_dly, w_img_dly} = w_dl_out;
`endif

    vga_pipe_delay #(
        .WIDTH     (c_dl_w),
        .DEPTH     (FB_LATENCY + 1),
        .RESET_VAL (c_dl_rst)
    ) u_align (
        .clk (pix_clk),
        .rst (reset),
        .i_d (w_dl_in),
        .o_q (w_dl_out)
    );

    rgb9_t w_sel;

    always_comb begin
        w_sel = '0;
        if (w_img_dly) begin
            w_sel = rgb;
`ifdef VGA_TESTPAT_EN
            if (tp_sel) begin
                w_sel = bar_rgb(w_bar_dly);
            end
`endif
        end else if (w_act_dly) begin
            w_sel = BORDER_RGB;
        end
    end

    rgb9_t r_col;
    logic  r_hs;
    logic  r_vs;
    logic  r_blank;
    logic  r_vbs;

    always_ff @(posedge pix_clk) begin
        if (reset) begin
            r_col   <= '0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_blank <= 1'b1;
            r_vbs   <= 1'b0;
        end else begin
            r_col   <= w_sel;
            r_hs    <= w_hs_n_dly;
            r_vs    <= w_vs_n_dly;
            r_blank <= !w_act_dly;
            r_vbs   <= (r_h_cnt == 10'd0) && (r_v_cnt == c_v_act);
        end
    end

    assign vga_r        = r_col[8:6];
    assign vga_g        = r_col[5:3];
    assign vga_b        = r_col[2:0];
    assign vga_hs       = r_hs;
    assign vga_vs       = r_vs;
    assign vga_blank    = r_blank;
    assign vblank_start = r_vbs;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module : tb_vga_timing
// Brief  : Checks two vga_timing instances (FB_LATENCY 1 and 2, shortened
//          vertical timing) cycle by cycle against a counter-arithmetic model.
// Rev    : 1.0  initial release
//============================================================================
module tb_vga_timing;

    localparam int         HT     = 800;
    localparam int         VA     = 16;
    localparam int         VF     = 2;
    localparam int         VS     = 2;
    localparam int         VB     = 3;
    localparam int         VT     = VA + VF + VS + VB;
    localparam int         FRAME  = HT * VT;
    localparam logic [8:0] BORDER = 9'h0A5;

    logic       clk = 1'b0;
    logic       reset;
    logic       tp;
    logic [8:0] bus;
    int         mode;

    logic [7:0] px   [2];
    logic [7:0] py   [2];
    logic [2:0] r    [2];
    logic [2:0] g    [2];
    logic [2:0] b    [2];
    logic       hs   [2];
    logic       vs   [2];
    logic       bl   [2];
    logic       vbs  [2];
    logic [8:0] rgb_in [2];

    logic [8:0] fb1  = '0;
    logic [8:0] fb2a = '0;
    logic [8:0] fb2b = '0;

    int tests = 0;
    int fails = 0;
    int n = 0;
    int first_fall = -1;
    int low_len = 0;
    int last_low = -1;
    int vbs_cnt = 0;
    logic hs_d = 1'b1;

    always #5 clk = ~clk;

    // Frame buffer models: contents {x[2:0], y[2:0], 3'h5}, read latency 1 and 2.
    always @(posedge clk) begin
        fb1  <= {px[0][2:0], py[0][2:0], 3'h5};
        fb2a <= {px[1][2:0], py[1][2:0], 3'h5};
        fb2b <= fb2a;
    end

    assign rgb_in[0] = (mode == 0) ? fb1  : bus;
    assign rgb_in[1] = (mode == 0) ? fb2b : bus;

    vga_timing #(
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FB_LATENCY(1), .BORDER_RGB(BORDER)
    ) u_dut1 (
        .pix_clk(clk), .reset(reset),
        .pix_ptr_x(px[0]), .pix_ptr_y(py[0]), .rgb(rgb_in[0]),
`ifdef VGA_TESTPAT_EN
        .tp_sel(tp),
`endif
        .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]),
        .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_blank(bl[0]),
        .vblank_start(vbs[0])
    );

    vga_timing #(
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FB_LATENCY(2), .BORDER_RGB(BORDER)
    ) u_dut2 (
        .pix_clk(clk), .reset(reset),
        .pix_ptr_x(px[1]), .pix_ptr_y(py[1]), .rgb(rgb_in[1]),
`ifdef VGA_TESTPAT_EN
        .tp_sel(tp),
`endif
        .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]),
        .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_blank(bl[1]),
        .vblank_start(vbs[1])
    );

    // Expected {hs, vs, blank, colour, vblank_start, ptr_x, ptr_y} after nn edges since reset.
    function automatic logic [28:0] model(int nn, int lat, int m, logic [8:0] pbus, logic ptp);
        int c, h, v;
        logic act, img, hsn, vsn, vb;
        logic [8:0] col;
        logic [7:0] mx, my, ax, ay;
        logic [2:0] kb;
        act = 1'b0; img = 1'b0; hsn = 1'b1; vsn = 1'b1; vb = 1'b0;
        col = '0; mx = '0; my = '0;
        if (nn >= lat) begin
            c = nn - lat;
            h = c % HT;
            v = (c / HT) % VT;
            act = (h < 640) && (v < VA);
            img = act && (h >= 64) && (h < 576);
            hsn = !((h >= 656) && (h < 752));
            vsn = !((v >= VA + VF) && (v < VA + VF + VS));
            if (img) begin
                ax = 8'((h - 64) / 2);
                ay = 8'(v / 2);
                kb = 3'((h - 64) / 64);
                if (ptp)         col = {{3{kb[2]}}, {3{kb[1]}}, {3{kb[0]}}};
                else if (m == 0) col = {ax[2:0], ay[2:0], 3'h5};
                else             col = pbus;
            end else if (act) begin
                col = BORDER;
            end
        end
        if (nn >= 1) begin
            c = nn - 1;
            h = c % HT;
            v = (c / HT) % VT;
            vb = (h == 0) && (v == VA);
            mx = ((h >= 64) && (h < 576) && (v < VA)) ? 8'((h - 64) / 2) : 8'd0;
            my = (v < VA) ? 8'(v / 2) : 8'd239;
        end
        return {hsn, vsn, !act, col, vb, mx, my};
    endfunction

    task automatic step();
        logic [28:0] got, exp;
        @(posedge clk);
        n = reset ? 0 : n + 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            exp = model(n, i + 3, mode, bus, tp);
            got = {hs[i], vs[i], bl[i], r[i], g[i], b[i], vbs[i], px[i], py[i]};
            tests++;
            assert (got === exp) else begin
                fails++;
                $error("FAIL pins_fbl%0d n=%0d got=%h exp=%h", i + 1, n, got, exp);
            end
        end
        if (hs_d && !hs[0] && first_fall < 0) first_fall = n;
        if (!hs[0]) low_len++;
        else if (!hs_d) begin
            last_low = low_len;
            low_len = 0;
        end
        if (vbs[0]) vbs_cnt++;
        hs_d = hs[0];
    endtask

    task automatic run(int cycles, int m);
        mode = m;
        for (int k = 0; k < cycles; k++) begin
            step();
            bus = (m == 1) ? 9'h1FF : (m == 2) ? 9'($urandom) : 9'h000;
`ifdef VGA_TESTPAT_EN
            tp = 1'($urandom);
`endif
        end
    endtask

    task automatic check_int(string tag, int got, int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        mode  = 0;
        bus   = '0;
        tp    = 1'b0;
        repeat (5) step();
        reset = 1'b0;

        run(FRAME, 0);
        check_int("first_hs_fall", first_fall, 656 + 3);
        check_int("hs_low_width", last_low, 96);

        run(FRAME / 2, 2);
        run(FRAME - FRAME / 2, 1);
        check_int("vblank_pulses_2frames", vbs_cnt, 2);

        // Mid-frame reset at (h=300, v=10) of the third frame.
        run(10 * HT + 300, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        first_fall = -1;
        last_low = -1;
        low_len = 0;
        vbs_cnt = 0;
        run(FRAME, 0);
        check_int("first_hs_fall_after_reset", first_fall, 656 + 3);
        check_int("hs_low_width_after_reset", last_low, 96);
        check_int("vblank_pulses_after_reset", vbs_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- VGA raster generator and output stage, directly downstream of the NES frame buffer.
- Generates 640x480@60 timing from a 25.175 MHz pix_clk.
- Drives pix_ptr_x/pix_ptr_y into the frame buffer for a 2x-scaled, horizontally centred 256x240 image.
- Re-aligns the returned 9-bit RRRGGGBBB colour with hsync/vsync/blank and drives the DAC pins.
- Emits a per-frame vblank pulse for the PPU.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- X_OFFSET, 64, first h_cnt of image area (left border width)
- FB_LATENCY, 1, cycles from pointer valid to rgb valid at frame buffer output (1..3)
- BORDER_RGB, 9'h000, colour in active area outside the image

Ports:
- pix_clk  in  1  pixel clock; sole clock
- reset  in  1  synchronous, active-high reset
- pix_ptr_x  out  8  frame buffer read column, 0..255
- pix_ptr_y  out  8  frame buffer read row, 0..239
- rgb  in  9  RRRGGGBBB from frame buffer, valid FB_LATENCY cycles after pointers
- vga_r  out  3  red to DAC
- vga_g  out  3  green to DAC
- vga_b  out  3  blue to DAC
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_blank  out  1  high outside the 640x480 active area
- vblank_start  out  1  one-cycle pulse at start of vertical blanking

Behaviour:
- Counters:
  - h_cnt wraps 0..799 (H_TOTAL=sum of H params); v_cnt wraps 0..524 and increments when h_cnt wraps.
  - Both are 10-bit unsigned.
- Raw, combinational from the counters:
  - active = h_cnt<640 && v_cnt<480
  - hs_n low for h_cnt in 656..751
  - vs_n low for v_cnt in 490..491
  - img = active && X_OFFSET<=h_cnt<X_OFFSET+512
- Pointers, registered from the counters:
  - pix_ptr_x = img ? (h_cnt-X_OFFSET)>>1 : 0.
  - pix_ptr_y = v_cnt<480 ? v_cnt>>1 : 239. This is always within 0..239, so the frame buffer never clamps.
- Alignment:
  - active, hs_n, vs_n and img pass through a (FB_LATENCY+1)-stage delay line so they coincide with rgb.
  - Outputs are registered one further stage.
  - Total latency from counter value to pin = FB_LATENCY+2 cycles; every pin is mutually aligned.
- Colour select, registered:
  - delayed img -> rgb
  - else delayed active -> BORDER_RGB
  - else 0
  - vga_r=sel[8:6], vga_g=sel[5:3], vga_b=sel[2:0].
- vblank_start: registered, high for exactly one cycle when h_cnt==0 && v_cnt==480. It is not delayed by the pipeline.
- Reset:
  - h_cnt=v_cnt=0, pointers=0, delay line cleared to inactive.
  - vga_hs=vga_vs=1, vga_blank=1, colour=0, vblank_start=0.
  - Reset asserted mid-line or mid-frame restarts at (0,0) on the cycle after deassertion. No partial sync pulse is emitted while reset is high.
- rgb is ignored whenever delayed img=0; X/garbage on it must not reach the pins.

Optional Feature:
- Macro VGA_TESTPAT_EN.
- Defined:
  - Adds input port tp_sel (1 bit).
  - When tp_sel=1, the image-area colour is replaced by 8 vertical bars, each 32 NES pixels wide: bar k = {k[2]?3'h7:0, k[1]?3'h7:0, k[0]?3'h7:0}, k=pix_ptr_x[7:5].
  - The bar index is delayed with the same alignment as rgb. Pointers still toggle normally.
  - tp_sel is sampled per pixel; no frame-boundary synchronisation.
- Undefined: no tp_sel port, no pattern logic; image area always shows rgb.

Decomposition:
- Package vga_pkg holds:
  - typedef rgb9_t (logic [8:0])
  - the 640x480 timing constants and H_TOTAL/V_TOTAL
  - NES_W=256, NES_H=240, SCALE_SHIFT=1
- Sub-module vga_pipe_delay: parameterised width/depth shift register with synchronous reset value. It is used for the sync/active/img (and test-pattern index) delay line.

Test Plan:
- Reset held 5 cycles, then released -> pins hs=1, vs=1, blank=1, rgb=0 during reset. First hs falling edge at cycle 656+FB_LATENCY+2 after release. hs low for exactly 96 cycles; period 800.
- Run 2 frames -> vs low for exactly 2x800 cycles per frame. Frame period 420000 cycles. vblank_start pulses once per frame, 480x800 cycles after frame start.
- Model frame buffer as rgb = {pix_ptr_x[2:0], pix_ptr_y[2:0], 3'h5} with FB_LATENCY=1 and 2 -> on line v=10, pixel h=64..65 shows ptr (0,5); h=575 shows ptr (255,5); h=0..63 and 576..639 show BORDER_RGB. All aligned with blank=0.
- Drive rgb=9'h1FF constantly -> pins 0 whenever blank=1 (h>=640 or v>=480). Lines 478/479 read pix_ptr_y=239; v>=480 pointer y stays 239.
- Assert reset mid-frame at h=300, v=200 for 1 cycle -> next cycle counters at (0,0); no truncated hs/vs pulse; the following timing is identical to the first scenario.
- With VGA_TESTPAT_EN and tp_sel=1 -> h=64..127 shows 9'h000; h=128..191 shows 9'h007; h=512..575 shows 9'h1FF; border unchanged.
